// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared types and helpers for the animated sprite sources.
//   anim_cmd_t   : animation command carried on anim_cmd
//   anim_state_t : frame-sequencer state
//   frame_bits() : index width for a frame count (never less than 1)
// -----------------------------------------------------------------------------
package sprite_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_ONCE = 2'b01,
    CMD_LOOP = 2'b10,
    CMD_STOP = 2'b11
  } anim_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ONCE = 2'b01,
    ST_LOOP = 2'b10
  } anim_state_t;

  // Scan coordinates are 11 bits; relative offsets get one extra sign bit.
  localparam int COORD_W = 11;
  localparam int REL_W   = 12;

  function automatic int frame_bits(input int frames);
    return (frames > 1) ? $clog2(frames) : 1;
  endfunction

endpackage

// File: rtl/sprite_frame_ram.sv
// -----------------------------------------------------------------------------
// sprite_frame_ram
// Simple dual-port bitmap store shared by the sprite sources.
//   clk     : clock
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address (sampled every cycle)
//   rd_data : registered read data, one cycle after rd_addr
// A read and a write to the same address in one cycle return the old word.
// -----------------------------------------------------------------------------
module sprite_frame_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // NOTE: the array has no reset so it maps onto block RAM; contents are
  // undefined until written, which the pixel path never depends on.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make the read below see the pre-write
    // word, which is exactly the read-first collision behaviour.
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/anim_sprite_src.sv
// -----------------------------------------------------------------------------
// anim_sprite_src
// Animated, palettised sprite source for the pixel pipeline.
//   clk, rst_n        : clock, asynchronous active-low reset
//   x, y              : current scan pixel
//   x0, y0            : sprite top-left corner
//   mirror            : horizontal flip
//   frame_tick        : one pulse per video frame, paces the animation
//   cmd_valid/anim_cmd: nop / play_once / loop / stop
//   rate              : frame_ticks per animation step (0 behaves as 1)
//   we/addr_w/pixel_in: bitmap write port, address {frame, row, col}
//   plt_we/plt_addr/plt_rgb : palette write port
//   sprite_rgb        : pixel colour, KEY_COLOR when transparent, 3-cycle latency
//   busy              : animation running
//   done              : one-cycle pulse when a play_once sequence ends
//   cur_frame         : frame index currently displayed
// -----------------------------------------------------------------------------
module anim_sprite_src
  import sprite_pkg::*;
#(
  parameter int            CD        = 12,
  parameter int            H_SIZE    = 8,
  parameter int            V_SIZE    = 80,
  parameter int            FRAMES    = 4,
  parameter int            PB        = 2,
  parameter logic [CD-1:0] KEY_COLOR = 12'h000,
  localparam int           HB        = $clog2(H_SIZE),
  localparam int           VB        = $clog2(V_SIZE),
  localparam int           FB        = frame_bits(FRAMES),
  localparam int           ADDR      = FB + VB + HB
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic               mirror,
  input  logic               frame_tick,
  input  logic               cmd_valid,
  input  logic [1:0]         anim_cmd,
  input  logic [7:0]         rate,
  input  logic               we,
  input  logic [ADDR-1:0]    addr_w,
  input  logic [PB-1:0]      pixel_in,
  input  logic               plt_we,
  input  logic [PB-1:0]      plt_addr,
  input  logic [CD-1:0]      plt_rgb,
  output logic [CD-1:0]      sprite_rgb,
  output logic               busy,
  output logic               done,
  output logic [FB-1:0]      cur_frame
);

  localparam int                      PLT_N      = 2 ** PB;
  localparam logic signed [REL_W-1:0] H_LIM      = REL_W'(H_SIZE);
  localparam logic signed [REL_W-1:0] V_LIM      = REL_W'(V_SIZE);
  localparam logic [HB-1:0]           COL_LAST   = HB'(H_SIZE - 1);
  localparam logic [FB-1:0]           LAST_FRAME = FB'(FRAMES - 1);

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------
  anim_state_t   state_q, state_d;
  logic [7:0]    tick_cnt_q, tick_cnt_d;
  logic [FB-1:0] cur_frame_q, cur_frame_d;
  logic          done_q, done_d;
  logic [7:0]    rate_last;

  assign rate_last = (rate == 8'd0) ? 8'd0 : rate - 8'd1;

  // NOTE: every variable gets its hold/default value first so that no path
  // through the case/if tree leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    cur_frame_d = cur_frame_q;
    done_d      = 1'b0;

    if (cmd_valid) begin
      // A command always wins over a coincident tick; the tick is dropped.
      unique case (anim_cmd_t'(anim_cmd))
        CMD_ONCE: begin
          state_d     = ST_ONCE;
          cur_frame_d = '0;
          tick_cnt_d  = '0;
        end
        CMD_LOOP: begin
          state_d     = ST_LOOP;
          cur_frame_d = '0;
          tick_cnt_d  = '0;
        end
        CMD_STOP: begin
          state_d    = ST_IDLE;
          tick_cnt_d = '0;
        end
        CMD_NOP: ;
      endcase
    end else if (frame_tick && (state_q != ST_IDLE)) begin
      // >= rather than == so that lowering rate mid-sequence cannot make the
      // counter run all the way round before the next step.
      if (tick_cnt_q >= rate_last) begin
        tick_cnt_d = '0;
        if (cur_frame_q == LAST_FRAME) begin
          cur_frame_d = '0;
          if (state_q == ST_ONCE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cur_frame_d = cur_frame_q + 1'b1;
        end
      end else begin
        tick_cnt_d = tick_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      cur_frame_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      cur_frame_q <= cur_frame_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign cur_frame = cur_frame_q;

  // ---------------------------------------------------------------------------
  // Palette: small register file, written one cycle, visible the next
  // ---------------------------------------------------------------------------
  logic [CD-1:0] palette_q [PLT_N];
  logic [CD-1:0] palette_d [PLT_N];

  always_comb begin
    palette_d = palette_q;
    if (plt_we) begin
      palette_d[plt_addr] = plt_rgb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PLT_N; i++) begin
        palette_q[i] <= '0;
      end
    end else begin
      palette_q <= palette_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel pipeline
  //   stage 0 (comb) : relative position, region test, mirrored column
  //   edge 1         : read address + in_region
  //   edge 2         : bitmap code (inside the RAM) + delayed in_region
  //   edge 3         : palette lookup -> sprite_rgb
  // ---------------------------------------------------------------------------
  logic signed [REL_W-1:0] xr, yr;
  logic [HB-1:0]           col;
  logic                    vld1_d;
  logic [ADDR-1:0]         rd_addr_d;

  always_comb begin
    xr = $signed({1'b0, x}) - $signed({1'b0, x0});
    yr = $signed({1'b0, y}) - $signed({1'b0, y0});
    vld1_d = !xr[REL_W-1] && (xr < H_LIM) && !yr[REL_W-1] && (yr < V_LIM);
    // Only the low HB bits matter; inside the region the modulo result equals
    // the full-width H_SIZE-1-xr.
    col = mirror ? (COL_LAST - xr[HB-1:0]) : xr[HB-1:0];
    rd_addr_d = {cur_frame_q, yr[VB-1:0], col};
  end

  logic [ADDR-1:0] rd_addr_q;
  logic            vld1_q, vld2_q;
  logic [PB-1:0]   rd_code;
  logic [CD-1:0]   sprite_rgb_q, sprite_rgb_d;

  sprite_frame_ram #(
    .ADDR_WIDTH (ADDR),
    .DATA_WIDTH (PB)
  ) u_frame_ram (
    .clk     (clk),
    .wr_en   (we),
    .wr_addr (addr_w),
    .wr_data (pixel_in),
    .rd_addr (rd_addr_q),
    .rd_data (rd_code)
  );

  // Code 0 is transparent whatever palette entry 0 holds.
  always_comb begin
    sprite_rgb_d = KEY_COLOR;
    if (vld2_q && (rd_code != '0)) begin
      sprite_rgb_d = palette_q[rd_code];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q    <= '0;
      vld1_q       <= 1'b0;
      vld2_q       <= 1'b0;
      sprite_rgb_q <= KEY_COLOR;
    end else begin
      rd_addr_q    <= rd_addr_d;
      vld1_q       <= vld1_d;
      vld2_q       <= vld1_q;
      sprite_rgb_q <= sprite_rgb_d;
    end
  end

  assign sprite_rgb = sprite_rgb_q;

endmodule

// File: tb/tb_anim_sprite_src.sv
// -----------------------------------------------------------------------------
// tb_anim_sprite_src
// Self-checking bench for anim_sprite_src with default parameters
// (12-bit colour, 8x80 sprite, 4 frames, 2-bit palette codes).
// Pixel results go through a scoreboard queue: the expected colour is pushed
// when (x, y) is driven and popped three clock edges later.
// -----------------------------------------------------------------------------
module tb_anim_sprite_src;
  import sprite_pkg::*;

  localparam int          ADDR = 12;
  localparam logic [11:0] KEY  = 12'h000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] x, y, x0, y0;
  logic        mirror, frame_tick, cmd_valid;
  logic [1:0]  anim_cmd;
  logic [7:0]  rate;
  logic        we;
  logic [ADDR-1:0] addr_w;
  logic [1:0]  pixel_in;
  logic        plt_we;
  logic [1:0]  plt_addr;
  logic [11:0] plt_rgb;
  logic [11:0] sprite_rgb;
  logic        busy, done;
  logic [1:0]  cur_frame;

  always #5 clk = ~clk;

  anim_sprite_src dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x),
    .y          (y),
    .x0         (x0),
    .y0         (y0),
    .mirror     (mirror),
    .frame_tick (frame_tick),
    .cmd_valid  (cmd_valid),
    .anim_cmd   (anim_cmd),
    .rate       (rate),
    .we         (we),
    .addr_w     (addr_w),
    .pixel_in   (pixel_in),
    .plt_we     (plt_we),
    .plt_addr   (plt_addr),
    .plt_rgb    (plt_rgb),
    .sprite_rgb (sprite_rgb),
    .busy       (busy),
    .done       (done),
    .cur_frame  (cur_frame)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard, reference bitmap/palette and counters
  // ---------------------------------------------------------------------------
  typedef struct {
    int          due;
    logic [11:0] exp;
    string       tag;
  } sb_entry_t;

  sb_entry_t   sb [$];
  int          cyc    = 0;
  int          n_vec  = 0;
  int          n_mis  = 0;
  logic [1:0]  bm  [4096];
  logic [11:0] plt [4];
  int          m_x0, m_y0, m_frame;

  int row0_codes [8] = '{2, 0, 1, 3, 0, 2, 1, 3};
  int row1_codes [8] = '{1, 3, 2, 0, 1, 2, 3, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pop every entry that has come due; outputs sampled 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_entry_t e;
      e = sb.pop_front();
      check(e.tag, 32'(sprite_rgb), 32'(e.exp));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Reference model of the pixel path
  // ---------------------------------------------------------------------------
  function automatic logic [11:0] model_pix(input int px, input int py, input bit mir);
    int xr, yr, col;
    logic [1:0] code;
    xr = px - m_x0;
    yr = py - m_y0;
    if (xr < 0 || xr >= 8 || yr < 0 || yr >= 80) return KEY;
    col  = mir ? 7 - xr : xr;
    code = bm[m_frame * 1024 + yr * 8 + col];
    return (code == 2'd0) ? KEY : plt[code];
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus tasks (entered and left on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic pix_exp(input int px, input int py, input bit mir,
                         input logic [11:0] exp, input string tag);
    x      = 11'(px);
    y      = 11'(py);
    mirror = mir;
    sb.push_back('{due: cyc + 3, exp: exp, tag: tag});
    @(negedge clk);
  endtask

  task automatic pix(input int px, input int py, input bit mir, input string tag);
    pix_exp(px, py, mir, model_pix(px, py, mir), tag);
  endtask

  task automatic wr_pix(input int f, input int r, input int c, input int code);
    we       = 1'b1;
    addr_w   = ADDR'(f * 1024 + r * 8 + c);
    pixel_in = 2'(code);
    @(negedge clk);
    we = 1'b0;
    bm[f * 1024 + r * 8 + c] = 2'(code);
  endtask

  task automatic wr_plt(input int idx, input logic [11:0] rgb);
    plt_we   = 1'b1;
    plt_addr = 2'(idx);
    plt_rgb  = rgb;
    @(negedge clk);
    plt_we = 1'b0;
    plt[idx] = rgb;
  endtask

  task automatic cmd(input anim_cmd_t c);
    cmd_valid = 1'b1;
    anim_cmd  = c;
    @(negedge clk);
    cmd_valid = 1'b0;
    anim_cmd  = CMD_NOP;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic fsm_chk(input string tag, input int f, input bit b, input bit d);
    check({tag, ".frame"}, 32'(cur_frame), 32'(f));
    check({tag, ".busy"},  32'(busy),      32'(b));
    check({tag, ".done"},  32'(done),      32'(d));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    x = '0; y = '0; x0 = 11'd100; y0 = 11'd100;
    mirror = 1'b0; frame_tick = 1'b0; cmd_valid = 1'b0; anim_cmd = CMD_NOP;
    rate = 8'd1; we = 1'b0; addr_w = '0; pixel_in = '0;
    plt_we = 1'b0; plt_addr = '0; plt_rgb = '0;
    m_x0 = 100; m_y0 = 100; m_frame = 0;

    repeat (3) @(negedge clk);
    check("rst.rgb", 32'(sprite_rgb), 32'(KEY));
    fsm_chk("rst", 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Bitmap and palette contents
    for (int c = 0; c < 8; c++) begin
      wr_pix(0, 0, c, row0_codes[c]);
      wr_pix(0, 1, c, row1_codes[c]);
    end
    wr_pix(0, 79, 0, 3);
    wr_pix(1, 0, 0, 3);
    wr_plt(0, 12'h123);   // code 0 must stay transparent anyway
    wr_plt(1, 12'h100);
    wr_plt(2, 12'hFFF);
    wr_plt(3, 12'h0A5);

    // Basic hit/miss, continuous scan of row 0, mirrored scan of row 1
    pix(100, 100, 1'b0, "hit_origin");
    pix(99, 100, 1'b0, "left_of_sprite");
    for (int xi = 98; xi < 110; xi++) pix(xi, 100, 1'b0, "scan_row0");
    pix(107, 101, 1'b1, "mirror_col0");
    pix(100, 101, 1'b1, "mirror_col7");
    for (int xi = 98; xi < 110; xi++) pix(xi, 101, 1'b1, "scan_row1_mir");
    pix(100, 99, 1'b0, "above_sprite");
    pix(100, 179, 1'b0, "last_row");
    pix(100, 180, 1'b0, "below_sprite");
    pix(2047, 100, 1'b0, "far_right");
    pix(0, 100, 1'b0, "far_left");

    // Origin change takes effect with the pixel it accompanies
    x0 = 11'd50; m_x0 = 50;
    pix(50, 100, 1'b0, "moved_origin_c0");
    pix(53, 100, 1'b0, "moved_origin_c3");
    x0 = 11'd100; m_x0 = 100;
    pix(100, 100, 1'b0, "origin_back");

    // Palette write coinciding with the lookup of the same entry
    pix_exp(100, 100, 1'b0, 12'hFFF, "plt_same_cycle_old");
    pix_exp(100, 100, 1'b0, 12'h0F0, "plt_next_new");
    plt_we = 1'b1; plt_addr = 2'd2; plt_rgb = 12'h0F0;
    pix(99, 100, 1'b0, "plt_gap");
    plt_we = 1'b0;
    plt[2] = 12'h0F0;
    pix(100, 100, 1'b0, "plt_after");
    x = '0; y = '0;
    repeat (5) @(negedge clk);
    check("sb_drain_pixels", 32'(sb.size()), 32'd0);

    // play_once, rate 2: frame steps every 2 ticks, done after the 8th
    rate = 8'd2;
    cmd(CMD_ONCE);
    fsm_chk("once_start", 0, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      fsm_chk($sformatf("once_tick%0d", i), (i == 8) ? 0 : i / 2, i != 8, i == 8);
    end
    @(negedge clk);
    fsm_chk("once_after", 0, 0, 0);

    // loop, rate 0 behaves as 1: advance every tick, wrap 3 -> 0
    rate = 8'd0;
    cmd(CMD_LOOP);
    fsm_chk("loop_start", 0, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      fsm_chk($sformatf("loop_tick%0d", i), i % 4, 1, 0);
    end
    cmd(CMD_STOP);
    fsm_chk("stop_hold", 1, 0, 0);
    tick();
    fsm_chk("stop_tick_ignored", 1, 0, 0);

    // Held frame 1 selects the frame-1 bitmap
    m_frame = 1;
    pix(100, 100, 1'b0, "frame1_pixel");
    x = '0; y = '0;
    repeat (5) @(negedge clk);
    check("sb_drain_frame1", 32'(sb.size()), 32'd0);

    // Restart while busy, with a tick in the same cycle as the command
    rate = 8'd2;
    cmd(CMD_LOOP);
    tick(); tick(); tick();
    fsm_chk("restart_pre", 1, 1, 0);
    cmd_valid = 1'b1; anim_cmd = CMD_ONCE; frame_tick = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; anim_cmd = CMD_NOP; frame_tick = 1'b0;
    fsm_chk("cmd_with_tick", 0, 1, 0);
    tick();
    fsm_chk("cmd_tick_next1", 0, 1, 0);
    tick();
    fsm_chk("cmd_tick_next2", 1, 1, 0);

    // Reset one tick before completion: immediate abort, no done pulse
    rate = 8'd1;
    cmd(CMD_ONCE);
    tick(); tick(); tick();
    fsm_chk("pre_reset", 3, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    fsm_chk("async_reset", 0, 0, 0);
    check("async_reset.rgb", 32'(sprite_rgb), 32'(KEY));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      fsm_chk($sformatf("post_reset%0d", i), 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
